// File: rtl/update_y_pkg.sv
// Shared definitions for the updateY datapath: FSM state encoding and default widths.
package update_y_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BURST   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_DONE    = 3'd3,
    ST_WAITLOW = 3'd4
  } upd_y_state_e;

  // Index width that stays legal (>= 1 bit) even for single-word bursts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/update_y_wr_pipe.sv
// Two-stage strobe -> capture -> write pipeline feeding the Y SRAM write port.
module update_y_wr_pipe #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int IDX_W     = 4,
  parameter int NUM_Y     = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_strobe_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_wr_o
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_Y - 1);

  logic              cap_vld_q;
  logic [IDX_W-1:0]  cap_idx_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  wr_idx_q;

  // Stage 1 tags the cycle whose read data is valid; stage 2 registers the SRAM write.
  always_ff @(posedge clock) begin
    if (reset) begin
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_idx_q  <= '0;
    end else begin
      cap_vld_q <= rd_strobe_i;
      cap_idx_q <= rd_idx_i;
      we_q      <= cap_vld_q;
      if (cap_vld_q) begin
        // Address sum is ADDR_W wide, so it wraps naturally past the top of the SRAM.
        addr_q   <= BASE + ADDR_W'(cap_idx_q);
        data_q   <= rd_data_i;
        wr_idx_q <= cap_idx_q;
      end else begin
        addr_q   <= addr_q;
        data_q   <= data_q;
        wr_idx_q <= wr_idx_q;
      end
    end
  end

  assign we_o      = we_q;
  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign last_wr_o = we_q && (wr_idx_q == LAST_IDX);

endmodule

// File: rtl/update_y_sram_writer.sv
// Streams NUM_Y words from the updateY result buffer into the Y SRAM, then pulses done.
module update_y_sram_writer
  import update_y_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int NUM_Y     = 16,
  parameter int BASE_ADDR = 0,
  localparam int IDX_W    = idx_width(NUM_Y),
  localparam int CNT_W    = $clog2(NUM_Y + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_writeYvalEnable,
  output logic              op_resBufRe,
  output logic [IDX_W-1:0]  op_resBufAddr,
  input  logic [DATA_W-1:0] in_resBufData,
  output logic              op_ySramWe,
  output logic [ADDR_W-1:0] op_ySramAddr,
  output logic [DATA_W-1:0] op_ySramWrData,
  output logic              op_updateYwriteDoneFlag,
  output logic              op_busy
);

  upd_y_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             re_q, re_d;
  logic [IDX_W-1:0] rb_addr_q, rb_addr_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             last_wr_s;

  // Next-state, read-issue and flag decisions; all results are registered below.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    re_d      = 1'b0;
    rb_addr_d = rb_addr_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_writeYvalEnable) begin
          re_d      = 1'b1;
          rb_addr_d = IDX_W'(0);
          cnt_d     = CNT_W'(1);
          state_d   = ST_BURST;
        end else begin
          cnt_d     = CNT_W'(0);
        end
      end
      ST_BURST: begin
        // cnt_q counts words already issued; a low enable simply holds it.
        if (cnt_q == CNT_W'(NUM_Y)) begin
          state_d = ST_DRAIN;
        end else if (in_writeYvalEnable) begin
          re_d      = 1'b1;
          rb_addr_d = cnt_q[IDX_W-1:0];
          cnt_d     = cnt_q + CNT_W'(1);
        end else begin
          cnt_d     = cnt_q;
        end
      end
      ST_DRAIN: begin
        if (last_wr_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_WAITLOW;
      end
      ST_WAITLOW: begin
        // The arbiter keeps enable high one cycle past done; wait it out.
        if (!in_writeYvalEnable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAITLOW;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_BURST) || (state_d == ST_DRAIN) || (state_d == ST_DONE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      re_q      <= 1'b0;
      rb_addr_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      re_q      <= re_d;
      rb_addr_q <= rb_addr_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  update_y_wr_pipe #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W),
    .NUM_Y    (NUM_Y),
    .BASE_ADDR(BASE_ADDR)
  ) u_wr_pipe (
    .clock      (clock),
    .reset      (reset),
    .rd_strobe_i(re_q),
    .rd_idx_i   (rb_addr_q),
    .rd_data_i  (in_resBufData),
    .we_o       (op_ySramWe),
    .addr_o     (op_ySramAddr),
    .data_o     (op_ySramWrData),
    .last_wr_o  (last_wr_s)
  );

  assign op_resBufRe             = re_q;
  assign op_resBufAddr           = rb_addr_q;
  assign op_updateYwriteDoneFlag = done_q;
  assign op_busy                 = busy_q;

endmodule

// File: tb/tb_update_y_sram_writer.sv
// Scoreboard bench for update_y_sram_writer: three instances (4 words @0x10, 1 word @0xFF, 2 words @0xFF).
module tb_update_y_sram_writer;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NYA [3] = '{4, 1, 2};
  localparam int BAA [3] = '{16, 255, 255};

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic          en   [3];
  logic          re   [3];
  logic [7:0]    rba  [3];
  logic [DW-1:0] rbd  [3];
  logic          we   [3];
  logic [AW-1:0] ya   [3];
  logic [DW-1:0] yd   [3];
  logic          done [3];
  logic          busy [3];
  logic [1:0]    rba0;
  logic          rba1;
  logic          rba2;

  assign rba[0] = 8'(rba0);
  assign rba[1] = 8'(rba1);
  assign rba[2] = 8'(rba2);

  logic [DW-1:0] rbuf [3][16];

  // Result buffer model: data appears the cycle after the read strobe.
  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (re[k]) rbd[k] <= rbuf[k][rba[k][3:0]];
    end
  end

  update_y_sram_writer #(.DATA_W(DW), .ADDR_W(AW), .NUM_Y(4), .BASE_ADDR(16)) u_dut0 (
    .clock(clock), .reset(reset), .in_writeYvalEnable(en[0]), .op_resBufRe(re[0]),
    .op_resBufAddr(rba0), .in_resBufData(rbd[0]), .op_ySramWe(we[0]), .op_ySramAddr(ya[0]),
    .op_ySramWrData(yd[0]), .op_updateYwriteDoneFlag(done[0]), .op_busy(busy[0]));

  update_y_sram_writer #(.DATA_W(DW), .ADDR_W(AW), .NUM_Y(1), .BASE_ADDR(255)) u_dut1 (
    .clock(clock), .reset(reset), .in_writeYvalEnable(en[1]), .op_resBufRe(re[1]),
    .op_resBufAddr(rba1), .in_resBufData(rbd[1]), .op_ySramWe(we[1]), .op_ySramAddr(ya[1]),
    .op_ySramWrData(yd[1]), .op_updateYwriteDoneFlag(done[1]), .op_busy(busy[1]));

  update_y_sram_writer #(.DATA_W(DW), .ADDR_W(AW), .NUM_Y(2), .BASE_ADDR(255)) u_dut2 (
    .clock(clock), .reset(reset), .in_writeYvalEnable(en[2]), .op_resBufRe(re[2]),
    .op_resBufAddr(rba2), .in_resBufData(rbd[2]), .op_ySramWe(we[2]), .op_ySramAddr(ya[2]),
    .op_ySramWrData(yd[2]), .op_updateYwriteDoneFlag(done[2]), .op_busy(busy[2]));

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_on  = 1'b0;
  int  st_q   [3][$];
  wr_t wr_q   [3][$];
  int  done_q [3][$];
  int  busy_lo [3] = '{1, 1, 1};
  int  busy_hi [3] = '{0, 0, 0};
  wr_t mon_e;

  function automatic void chk(input string name, input int k, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d: got %0d, expected %0d", name, k, cyc, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name, input int k, input int act);
    n_tests++;
    n_fail++;
    $display("FAIL %s dut%0d cyc=%0d: got event (value %0d), expected none", name, k, cyc, act);
  endfunction

  // Monitor: every strobe, write and done pulse must match the head of its queue.
  always @(negedge clock) begin
    if (mon_on) begin
      for (int k = 0; k < 3; k++) begin
        if (re[k]) begin
          if (st_q[k].size() == 0) unexpected("strobe", k, int'(rba[k]));
          else chk("strobe_addr", k, int'(rba[k]), st_q[k].pop_front());
        end
        if (we[k]) begin
          if (wr_q[k].size() == 0) unexpected("write", k, int'(ya[k]));
          else begin
            mon_e = wr_q[k].pop_front();
            chk("wr_addr", k, int'(ya[k]), int'(mon_e.addr));
            chk("wr_data", k, int'(yd[k]), int'(mon_e.data));
            chk("wr_cycle", k, cyc, mon_e.cyc);
          end
        end
        if (done[k]) begin
          if (done_q[k].size() == 0) unexpected("done", k, cyc);
          else chk("done_cycle", k, cyc, done_q[k].pop_front());
        end
        chk("busy", k, int'(busy[k]), int'(cyc >= busy_lo[k] && cyc <= busy_hi[k]));
      end
    end
  end

  // Word i is issued in the i-th cycle (from T) with enable high; strobe +1, write +3, done after last write.
  task automatic run_burst(input int k, input bit fixed, input logic [15:0] pat_in, input int plen);
    int t0, ny, done_c, c;
    int ic[$];
    logic [15:0] pat;
    wr_t w;
    pat = pat_in | 16'h0001;
    ny  = NYA[k];
    for (int i = 0; i < ny; i++) rbuf[k][i] = fixed ? 16'(i + 1) : 16'($urandom);
    t0 = cyc;
    c  = t0;
    while (ic.size() < ny) begin
      if ((c - t0 >= plen) || pat[c - t0]) ic.push_back(c);
      c++;
    end
    done_c = ic[ny-1] + 4;
    for (int i = 0; i < ny; i++) begin
      st_q[k].push_back(i);
      w.cyc  = ic[i] + 3;
      w.addr = AW'(BAA[k] + i);
      w.data = rbuf[k][i];
      wr_q[k].push_back(w);
    end
    done_q[k].push_back(done_c);
    busy_lo[k] = t0 + 1;
    busy_hi[k] = done_c;
    for (int cc = t0; cc <= done_c + 1; cc++) begin
      en[k] = ((cc - t0 < plen) && (cc < done_c)) ? pat[cc - t0] : 1'b1;
      @(negedge clock);
    end
    en[k] = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  // Reset sampled at the edge that would register word 1's write: burst aborts, no done.
  task automatic run_reset_case();
    int t0;
    wr_t w;
    for (int i = 0; i < 4; i++) rbuf[0][i] = 16'($urandom);
    t0 = cyc;
    for (int i = 0; i < 3; i++) st_q[0].push_back(i);
    w.cyc  = t0 + 3;
    w.addr = AW'(BAA[0]);
    w.data = rbuf[0][0];
    wr_q[0].push_back(w);
    busy_lo[0] = t0 + 1;
    busy_hi[0] = t0 + 3;
    en[0] = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    en[0] = 1'b0;
    chk("rst_we", 0, int'(we[0]), 0);
    chk("rst_re", 0, int'(re[0]), 0);
    chk("rst_done", 0, int'(done[0]), 0);
    chk("rst_busy", 0, int'(busy[0]), 0);
    chk("rst_yaddr", 0, int'(ya[0]), 0);
    chk("rst_ydata", 0, int'(yd[0]), 0);
    chk("rst_rbaddr", 0, int'(rba[0]), 0);
    repeat (6) @(negedge clock);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) en[k] = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("init_we", k, int'(we[k]), 0);
      chk("init_re", k, int'(re[k]), 0);
      chk("init_done", k, int'(done[k]), 0);
      chk("init_busy", k, int'(busy[k]), 0);
      chk("init_yaddr", k, int'(ya[k]), 0);
    end
    mon_on = 1'b1;
    @(negedge clock);

    run_burst(0, 1'b1, 16'h0001, 1);
    run_burst(0, 1'b1, 16'b00011, 5);
    run_burst(0, 1'b0, 16'h0001, 1);
    run_reset_case();
    run_burst(0, 1'b0, 16'h0001, 1);
    run_burst(1, 1'b0, 16'h0001, 1);
    run_burst(2, 1'b0, 16'h0001, 1);
    for (int r = 0; r < 10; r++) begin
      run_burst($urandom_range(0, 2), 1'b0, 16'($urandom), $urandom_range(1, 10));
    end

    for (int k = 0; k < 3; k++) begin
      chk("strobes_left", k, st_q[k].size(), 0);
      chk("writes_left", k, wr_q[k].size(), 0);
      chk("dones_left", k, done_q[k].size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/update_y_sram_writer.md
Name: update_y_sram_writer

Overview:
- Downstream consumer of the updateY arbiter's write-enable.
- Once the updateY control path has finished computing, it streams NUM_Y computed Y words from the updateY result buffer into the Y SRAM.
- Asserts a one-cycle done flag; the arbiter uses it to drop both enables.
- Pipelined at one word per cycle after a 2-cycle fill.

Parameters:
- DATA_W, 16, width of one Y word.
- ADDR_W, 8, Y SRAM address width.
- NUM_Y, 16, words per burst; legal range 1..2**ADDR_W.
- BASE_ADDR, 0, Y SRAM address of word 0.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_writeYvalEnable  in  1  level enable from arbiter.
- op_resBufRe  out  1  result buffer read strobe.
- op_resBufAddr  out  $clog2(NUM_Y)  result buffer read address.
- in_resBufData  in  DATA_W  read data, valid exactly 1 cycle after strobe.
- op_ySramWe  out  1  Y SRAM write enable.
- op_ySramAddr  out  ADDR_W  Y SRAM write address.
- op_ySramWrData  out  DATA_W  Y SRAM write data.
- op_updateYwriteDoneFlag  out  1  one-cycle pulse at end of burst.
- op_busy  out  1  high from burst start through the done pulse.

Behaviour:
- Decided interface: one clock; reset is synchronous and active-high; ports named clock and reset.
- All outputs registered.
- Reset value of every output is 0; the counter resets to 0 and the FSM to IDLE.
- Reset asserted mid-burst aborts the burst with no done pulse. The same-edge write is suppressed; reset wins.
- FSM states: IDLE, BURST, DRAIN, DONE, WAITLOW.
- IDLE -> BURST when in_writeYvalEnable=1, with rdCnt=0.
- BURST:
  - Each cycle with enable=1: op_resBufRe=1, op_resBufAddr=rdCnt, rdCnt++.
  - Leave for DRAIN after issuing address NUM_Y-1.
  - Enable=0 in BURST pauses issue (strobe=0, counter held). Resume at the same rdCnt when enable returns.
- Write stage:
  - A read strobe issued in cycle k is captured in cycle k+1 and written in cycle k+2.
  - op_ySramWe=1, op_ySramAddr=BASE_ADDR+index (mod 2**ADDR_W), op_ySramWrData=captured data.
  - In-flight reads always complete their write, even while paused or in DRAIN.
- DRAIN: waits until the last write (index NUM_Y-1) has been performed, then -> DONE.
- DONE: op_updateYwriteDoneFlag=1 for exactly one cycle, the cycle after the last write; then -> WAITLOW.
- WAITLOW:
  - Stays until in_writeYvalEnable=0, then -> IDLE.
  - Prevents a second burst, because the arbiter drops enable one cycle after the done flag.
- Latency: enable first seen in IDLE at cycle T.
  - First strobe at T+1; first write at T+3.
  - Last write at T+2+NUM_Y; done pulse at T+3+NUM_Y, with no pauses.
- NUM_Y=1: a single strobe and a single write; DRAIN is still traversed.
- op_busy=1 in BURST, DRAIN and DONE; 0 in IDLE and WAITLOW.
- Addresses wrap modulo 2**ADDR_W; no error is flagged.

Decomposition:
- Shared package (update_y_pkg): FSM state enum typedef, default DATA_W/ADDR_W, shared by the arbiter and the control path.
- One natural sub-module: update_y_wr_pipe.
  - A 2-stage valid/index/data pipeline: strobe -> capture -> write.
  - Reports a "last write done" flag to the FSM.
- The FSM and counter stay in the top module.

Test Plan:
1. Setup: NUM_Y=4, BASE_ADDR=0x10, buffer={0x0001,0x0002,0x0003,0x0004}; raise enable at T. -> Writes 0x10..0x13 with those data at T+3..T+6; done=1 only at T+7; op_busy=1 from T+1 through T+7.
2. Same setup; drop enable for 3 cycles after the strobe for address 1. -> The write of word 1 still occurs. Strobes resume at address 2; 4 writes total, in order. Done is delayed by 3 cycles.
3. Arbiter behaviour modelled: enable stays high 1 cycle after done, then falls. -> No new strobe; FSM reaches IDLE. A later enable starts a fresh burst at address 0.
4. Reset pulsed in the cycle of the 2nd write. -> No SRAM write that edge; all outputs 0 next cycle; no done pulse. A new enable restarts from word 0.
5. NUM_Y=1, BASE_ADDR=0xFF, ADDR_W=8. -> One write to 0xFF at T+3; done at T+4.
6. NUM_Y=2, BASE_ADDR=0xFF. -> Writes to 0xFF then 0x00 (wrap); done at T+5.
